gtp_frame_tx: RTL

Self-triggered waveform framer between the four ADC receivers and one GTP transmit lane, on the 125 MHz receiver clock. Continuously buffers one selected ADC channel in a ring. On a rising threshold crossing it emits one frame to the GTP lane: header, pre/post-trigger samples, trailer. When idle it emits K28.5 commas.

---
 rtl/gtp_frame_tx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gtp_frame_tx.sv
// Self-triggered ADC waveform framer feeding one GTP lane: ring-buffers one channel, frames a window on a rising threshold crossing.
// Optional FRAME_CHECKSUM_EN: trailer carries the 12-bit sample sum; otherwise the trailer is the constant 16'hEFFF.
module gtp_frame_tx #(
  parameter int WINLEN = 32,
  parameter int PRE    = 8,
  parameter int BUFAW  = 6
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [191:0] D,
  input  logic [3:0]   CHSEL,
  input  logic [11:0]  THR,
  input  logic         ENABLE,
  output logic [15:0]  TXDATA,
  output logic         TXK,
  output logic         BUSY,
  output logic [15:0]  TRIGCNT
);

  localparam int DATA_W = 12;
  localparam int DEPTH  = 2 ** BUFAW;
  localparam int IW     = 8;

  typedef enum logic [1:0] {IDLE, HDR, SMP, TRL} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] ring [DEPTH];
  logic [BUFAW-1:0]  wptr;
  logic [BUFAW-1:0]  rptr;
  logic [BUFAW:0]    fill;
  logic [3:0]        chs_r;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] samp_p0;
  logic [DATA_W-1:0] prev_p1;
  logic [DATA_W-1:0] ck_word;
  logic [15:0]       tx_nx;
  logic              txk_nx;
  logic              fill_full;
  logic              trig;

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] ck;

  // Sum of 12-bit samples wraps modulo 4096 by construction.
  function automatic logic [DATA_W-1:0] ck_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  always_ff @(posedge CLK) begin
    if (trig)
      ck <= '0;
    else if (state == SMP)
      ck <= ck_add(ck, ring[rptr]);
  end

  assign ck_word = ck;
`else
  assign ck_word = 12'hFFF;
`endif

  // Stage p0: live selected sample; p1: previous sample for edge detection.
  assign samp_p0   = D[32'(CHSEL) * DATA_W +: DATA_W];
  assign fill_full = fill[BUFAW];
  assign trig      = (state == IDLE) && ENABLE && fill_full &&
                     (samp_p0 > THR) && (prev_p1 <= THR);
  assign BUSY      = (state != IDLE);

  // Ring and read pointer are pure datapath and never reset.
  always_ff @(posedge CLK) begin
    ring[wptr] <= samp_p0;
    prev_p1    <= samp_p0;
    if (trig)
      rptr <= wptr - BUFAW'(PRE);
    else if (state == SMP)
      rptr <= rptr + 1'b1;
  end

  always_comb begin
    state_nx = state;
    tx_nx    = {8'h00, 8'hBC};
    txk_nx   = 1'b1;
    case (state)
      IDLE: if (trig) state_nx = HDR;
      HDR: begin
        state_nx = SMP;
        tx_nx    = {4'hA, chs_r, TRIGCNT[7:0]};
        txk_nx   = 1'b0;
      end
      SMP: begin
        if (idx == IW'(WINLEN - 1)) state_nx = TRL;
        tx_nx  = {4'h0, ring[rptr]};
        txk_nx = 1'b0;
      end
      TRL: begin
        state_nx = IDLE;
        tx_nx    = {4'hE, ck_word};
        txk_nx   = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p2: registered lane word; the ring read lands here one cycle after its address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      wptr    <= '0;
      fill    <= '0;
      chs_r   <= '0;
      idx     <= '0;
      TRIGCNT <= '0;
      TXDATA  <= 16'h00BC;
      TXK     <= 1'b1;
    end else begin
      state  <= state_nx;
      TXDATA <= tx_nx;
      TXK    <= txk_nx;
      wptr   <= wptr + 1'b1;
      if (state == IDLE && CHSEL != chs_r) begin
        chs_r <= CHSEL;
        fill  <= '0;
      end else if (!fill_full) begin
        fill <= fill + 1'b1;
      end
      if (trig)
        TRIGCNT <= TRIGCNT + 16'd1;
      if (state == HDR)
        idx <= '0;
      else if (state == SMP)
        idx <= idx + 1'b1;
    end
  end

endmodule
